// File: rtl/sp_ram_pkg.sv
// Shared widths and enums for the single-port RAM FIFO controller.
package sp_ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {GNT_IDLE, GNT_WR, GNT_RD} gnt_e;
    typedef enum logic {PRI_RD, PRI_WR} pri_e;

endpackage

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller driving a single-port RAM: one RAM access per cycle,
// with the head word held in a registered output stage.
module sp_ram_fifo_ctrl
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   level
);

    localparam int             DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    // Both streams use valid/ready: a transfer happens on an edge where
    // valid && ready are both high; valid must not depend on ready.

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    pri_e              pri;
    gnt_e              gnt;
    logic              want_rd;
    logic              want_wr;

    assign want_rd = (ram_cnt != '0) && (!out_valid || out_ready);
    assign want_wr = in_valid && (ram_cnt != FULL_CNT);

    always_comb begin
        gnt = GNT_IDLE;
        if (!rst_n) begin
            gnt = GNT_IDLE;
        end else if (want_rd && want_wr) begin
            gnt = (pri == PRI_RD) ? GNT_RD : GNT_WR;
        end else if (want_rd) begin
            gnt = GNT_RD;
        end else if (want_wr) begin
            gnt = GNT_WR;
        end
    end

    assign in_ready  = (ram_cnt != FULL_CNT) && (!want_rd || pri == PRI_WR);
    assign ram_wr    = (gnt == GNT_WR);
    assign ram_rd    = (gnt == GNT_RD);
    assign ram_addr  = (gnt == GNT_WR) ? wr_ptr : rd_ptr;
    assign ram_wdata = in_data;
    assign level     = ram_cnt + (ADDR_W + 1)'(out_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            pri       <= PRI_RD;
        end else begin
            case (gnt)
                GNT_WR: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    ram_cnt <= ram_cnt + 1'b1;
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
                GNT_RD: begin
                    out_data  <= ram_rdata;
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                    ram_cnt   <= ram_cnt - 1'b1;
                end
                default: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
            endcase
            // The arbiter only moves when both sides actually compete.
            if (want_rd && want_wr) begin
                pri <= (pri == PRI_RD) ? PRI_WR : PRI_RD;
            end
        end
    end

endmodule

// File: doc/sp_ram_fifo_ctrl.md
Name: sp_ram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the team's 8x8 single-port RAM and drives its clk/wr/rd/addr/data_in pins.
- Turns a valid/ready push stream and a valid/ready pop stream into RAM accesses, with at most one RAM access per cycle.
- Holds the head word in an output register so that the pop side sees registered data.
- The RAM reads combinationally and drives Z when not reading, so the controller samples ram_rdata only in cycles where it asserts ram_rd.

Parameters:
- DATA_W, 8, word width; must match the RAM width.
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W (derived, not overridable); ADDR_W >= 1.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  DATA_W  push data.
- in_valid  input  1  push request.
- in_ready  output  1  push accepted when in_valid && in_ready.
- out_data  output  DATA_W  head-of-queue word (output register).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- ram_wr  output  1  to RAM wr.
- ram_rd  output  1  to RAM rd.
- ram_addr  output  ADDR_W  to RAM addr.
- ram_wdata  output  DATA_W  to RAM data_in; always equal to in_data.
- ram_rdata  input  DATA_W  from RAM data_out; Z unless ram_rd = 1.
- level  output  ADDR_W+1  words held, counting the RAM plus the output register; range 0..DEPTH+1.

Behaviour:
- Reset: the clock is single and the reset is synchronous active-low, evaluated on the rising edge of clk.
  - While rst_n = 0 at an edge: wr_ptr, rd_ptr and ram_cnt clear to 0; out_valid = 0, out_data = 0, pri = PRI_RD, level = 0.
  - During reset, ram_wr = 0 and ram_rd = 0.
  - Reset mid-stream discards all words. RAM contents are not cleared and are never read before being rewritten.
- Internal state:
  - wr_ptr, rd_ptr: ADDR_W bits, wrap DEPTH-1 -> 0 naturally.
  - ram_cnt: 0..DEPTH.
  - pri: PRI_RD or PRI_WR, the 2-state conflict-arbiter FSM.
- Request terms (combinational):
  - want_rd = (ram_cnt != 0) && (!out_valid || out_ready)
  - want_wr = in_valid && (ram_cnt != DEPTH)
- Grant rules (one of WRITE / READ / IDLE per cycle):
  - want_rd only -> READ. want_wr only -> WRITE. Neither -> IDLE.
  - Both -> pri decides: PRI_RD gives READ and pri becomes PRI_WR; PRI_WR gives WRITE and pri becomes PRI_RD.
  - pri changes only on conflict cycles.
- in_ready = (ram_cnt != DEPTH) && (!want_rd || pri == PRI_WR).
  - Independent of in_valid.
  - Combinationally dependent on out_ready; this path is permitted.
- WRITE cycle:
  - ram_wr = 1, ram_addr = wr_ptr.
  - At the edge: RAM stores in_data, wr_ptr++, ram_cnt++.
- READ cycle:
  - ram_rd = 1, ram_addr = rd_ptr.
  - At the edge: out_data <= ram_rdata, out_valid <= 1, rd_ptr++, ram_cnt--.
- IDLE cycle:
  - ram_wr = ram_rd = 0, ram_addr = rd_ptr.
  - If out_valid && out_ready, out_valid <= 0 at the edge.
- ram_wr and ram_rd are never both 1.
- Latency: a word pushed at edge N is readable in cycle N+1, so out_valid rises at edge N+1 at the earliest. Minimum push-to-out_valid is 2 cycles.
- Throughput: one RAM op per cycle. Sustained simultaneous push+pop therefore alternates, giving at most 1 word per 2 cycles each way.
- Boundaries:
  - Full (ram_cnt = DEPTH): in_ready = 0 and the write is blocked; reads still proceed.
  - Empty (ram_cnt = 0): no READ is issued; out_valid stays until consumed.
  - Pointers wrap silently.
- level = ram_cnt + out_valid, registered-consistent; it changes only at edges.

Decomposition:
- Package sp_ram_pkg holds:
  - DATA_W and ADDR_W defaults.
  - Grant enum {GNT_IDLE, GNT_WR, GNT_RD}.
  - Priority enum {PRI_RD, PRI_WR}.
- No sub-module. The top-level test harness instantiates this block plus the existing RAM.

Test Plan:
- Reset then idle 5 cycles -> in_ready = 1, out_valid = 0, level = 0, ram_wr = ram_rd = 0 throughout.
- Push 0x11 for one cycle with out_ready = 1 -> ram_wr = 1 with addr 0 in that cycle; ram_rd = 1 with addr 0 the next cycle; out_valid = 1 and out_data = 0x11 one cycle later; level goes 1 then 1 then 0 after the pop.
- Push 0x00..0x08 with out_ready = 0 -> first word in out_data, 8 words in RAM, level = 9, in_ready = 0. Then drain with out_ready = 1 -> outputs 0x00..0x08 in order, wr_ptr/rd_ptr wrap to 1.
- Continuous push (0xA0, 0xA1, ...) and out_ready = 1 from 2 words pre-loaded -> ram_rd and ram_wr alternate on conflict cycles, no word lost or duplicated, order preserved.
- Assert rst_n = 0 for 1 cycle with level = 5 -> next cycle level = 0, out_valid = 0; a subsequent push of 0x5A pops as 0x5A (not stale data).
- Fill to full, then set in_valid = 1 with out_ready = 0 for 10 cycles -> in_ready stays 0, ram_wr never asserts, level stays 9.
